axi_mem_scheduler: RTL and testbench

- Single-outstanding AXI3 master scheduler between the CPU instruction-fetch port (read-only) and the data port (read/write).
- Replaces the combinational pass-through with a real channel-sequencing FSM:
  - explicit valid/ready handshakes on AR/R/AW/W/B;
  - per-requester done pulses;
  - round-robin fairness when both ports request at once.
- Sits between core memory stage and AXI crossbar; stall outputs feed pipeline control.

---
 rtl/axi_mem_scheduler.sv | 178 +++++++++++++++++
 tb/tb_axi_mem_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_scheduler.sv
// Single-outstanding AXI3 master that sequences instruction-fetch and data-port
// requests onto one AXI interface, round-robin between the two requesters.
module axi_mem_scheduler #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_done,
  output logic        inst_stall,
  input  logic        data_req,
  input  logic [3:0]  data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_done,
  output logic        data_stall,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE, RADDR, RDATA, WADDR_DATA, WRESP, DONE
  } state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;            // 1 = data port
  logic        last_grant_q, last_grant_d;  // 1 = data port
  logic [31:0] addr_q, addr_d;
  logic [3:0]  we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        grant_data;
  logic        aw_ok, w_ok;

  // Response IDs/status are not acted on with only one transaction in flight.
  logic unused_inputs;
  assign unused_inputs = ^{rid, rresp, bid, bresp};

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    grant_data   = 1'b0;
    aw_ok        = 1'b0;
    w_ok         = 1'b0;
    case (state_q)
      IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (inst_req || data_req) begin
          // On contention the port that did not win last time is served.
          grant_data   = data_req && (!inst_req || !last_grant_q);
          owner_d      = grant_data;
          last_grant_d = grant_data;
          addr_d       = grant_data ? data_addr : inst_addr;
          we_d         = grant_data ? data_we : '0;
          wdata_d      = grant_data ? data_wdata : '0;
          state_d      = (grant_data && (data_we != '0)) ? WADDR_DATA : RADDR;
        end
      end
      RADDR: if (arready) state_d = RDATA;
      RDATA: begin
        if (rvalid && rlast) begin
          if (owner_q) data_rdata_d = rdata;
          else         inst_rdata_d = rdata;
          state_d = DONE;
        end
      end
      WADDR_DATA: begin
        aw_ok     = aw_done_q || awready;
        w_ok      = w_done_q || wready;
        aw_done_d = aw_ok;
        w_done_d  = w_ok;
        if (aw_ok && w_ok) state_d = WRESP;
      end
      WRESP: if (bvalid) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b0;
      addr_q       <= '0;
      we_q         <= '0;
      wdata_q      <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
    end
  end

  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;
  assign inst_done  = (state_q == DONE) && !owner_q;
  assign data_done  = (state_q == DONE) && owner_q;
  assign inst_stall = inst_req && !inst_done;
  assign data_stall = data_req && !data_done;

  assign arid    = owner_q ? DATA_ID : INST_ID;
  assign araddr  = addr_q;
  assign arlen   = '0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arvalid = (state_q == RADDR);
  assign rready  = (state_q == RDATA);

  assign awid    = owner_q ? DATA_ID : INST_ID;
  assign awaddr  = addr_q;
  assign awlen   = '0;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign awvalid = (state_q == WADDR_DATA) && !aw_done_q;
  assign wid     = owner_q ? DATA_ID : INST_ID;
  assign wdata   = wdata_q;
  assign wstrb   = we_q;
  assign wvalid  = (state_q == WADDR_DATA) && !w_done_q;
  assign wlast   = wvalid;
  assign bready  = (state_q == WRESP);

endmodule

// File: tb/tb_axi_mem_scheduler.sv
// Directed self-checking bench for axi_mem_scheduler; slave driven either by
// hand per cycle or by a zero-wait responder.
module tb_axi_mem_scheduler;

  logic        clk, rst;
  logic        inst_req, inst_done, inst_stall;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_done, data_stall;
  logic [3:0]  data_we;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  arid, arlen, awid, awlen, wid, wstrb, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic        auto_en = 1'b0;
  logic [31:0] auto_rdata = '0;

  axi_mem_scheduler #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_done(inst_done), .inst_stall(inst_stall),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_done(data_done),
    .data_stall(data_stall),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic clear_slave();
    arready = 0; rvalid = 0; rlast = 0; rdata = '0; rresp = '0; rid = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = '0; bid = '0;
  endtask

  // Zero-wait slave: answers every valid/ready on the following edge.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_en) begin
        arready = arvalid;
        rvalid  = rready;
        rlast   = 1'b1;
        rresp   = 2'b00;
        rdata   = auto_rdata;
        awready = awvalid;
        wready  = wvalid;
        bvalid  = bready;
      end
    end
  end

  initial begin
    int unsigned inst_cnt, ngrants;
    logic        data_fin, stall_bad, found;
    logic [3:0]  grants [0:7];

    rst = 0; inst_req = 0; inst_addr = '0; data_req = 0; data_we = '0;
    data_addr = '0; data_wdata = '0;
    clear_slave();
    repeat (2) @(negedge clk);
    check("rst_arvalid", arvalid, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_bready", bready, 0);
    check("rst_inst_done", inst_done, 0);
    check("rst_data_done", data_done, 0);
    check("rst_inst_rdata", inst_rdata, 0);
    check("rst_data_rdata", data_rdata, 0);
    check("const_arsize", arsize, 3'b010);
    check("const_arburst", arburst, 2'b01);
    check("const_awlen", awlen, 0);
    rst = 1;

    // Instruction read, zero-wait slave
    auto_rdata = 32'h3C08BFC0; auto_en = 1;
    @(negedge clk); inst_addr = 32'hBFC00000; inst_req = 1;
    @(negedge clk);
    check("t1_arvalid", arvalid, 1);
    check("t1_araddr", araddr, 32'hBFC00000);
    check("t1_arid", arid, 0);
    check("t1_arlen", arlen, 0);
    check("t1_stall", inst_stall, 1);
    @(negedge clk);
    check("t1_rready", rready, 1);
    check("t1_done_early", inst_done, 0);
    @(negedge clk);
    check("t1_done", inst_done, 1);
    check("t1_rdata", inst_rdata, 32'h3C08BFC0);
    check("t1_stall_done", inst_stall, 0);
    inst_req = 0;
    @(negedge clk);
    check("t1_done_pulse", inst_done, 0);
    check("t1_rdata_hold", inst_rdata, 32'h3C08BFC0);

    // Data write, W before AW, delayed B
    auto_en = 0; clear_slave();
    data_addr = 32'h80001000; data_we = 4'b0011; data_wdata = 32'hDEADBEEF; data_req = 1;
    @(negedge clk);
    check("t2_awvalid", awvalid, 1);
    check("t2_wvalid", wvalid, 1);
    check("t2_arvalid", arvalid, 0);
    check("t2_awaddr", awaddr, 32'h80001000);
    check("t2_wdata", wdata, 32'hDEADBEEF);
    check("t2_wstrb", wstrb, 4'b0011);
    check("t2_awid", awid, 1);
    check("t2_wid", wid, 1);
    check("t2_wlast", wlast, 1);
    wready = 1;
    @(negedge clk); wready = 0;
    check("t2_wvalid_drop", wvalid, 0);
    check("t2_awvalid_hold", awvalid, 1);
    @(negedge clk);
    check("t2_awvalid_hold2", awvalid, 1);
    awready = 1;
    @(negedge clk); awready = 0;
    check("t2_awvalid_drop", awvalid, 0);
    check("t2_bready", bready, 1);
    check("t2_no_done", data_done, 0);
    @(negedge clk);
    check("t2_wait_b1", data_done, 0);
    @(negedge clk);
    check("t2_wait_b2", data_done, 0);
    bvalid = 1;
    @(negedge clk); bvalid = 0;
    check("t2_done", data_done, 1);
    check("t2_stall_done", data_stall, 0);
    data_req = 0; data_we = '0;
    @(negedge clk);
    check("t2_done_pulse", data_done, 0);

    // Contention: last grant was data, so inst, data, inst
    auto_rdata = 32'h11112222; auto_en = 1;
    inst_addr = 32'h00001000; data_addr = 32'h00002000; data_we = '0;
    inst_req = 1; data_req = 1;
    inst_cnt = 0; ngrants = 0; data_fin = 0; stall_bad = 0;
    for (int cyc = 0; cyc < 60 && !(inst_cnt == 2 && data_fin); cyc++) begin
      @(negedge clk);
      if (arvalid && ngrants < 8) begin grants[ngrants] = arid; ngrants++; end
      if (data_req && !data_done && !data_stall) stall_bad = 1;
      if (inst_done) begin inst_cnt++; if (inst_cnt == 2) inst_req = 0; end
      if (data_done) begin data_fin = 1; data_req = 0; end
    end
    check("t3_finished", (inst_cnt == 2 && data_fin) ? 1 : 0, 1);
    check("t3_ngrants", ngrants, 3);
    check("t3_grant0", grants[0], 0);
    check("t3_grant1", grants[1], 1);
    check("t3_grant2", grants[2], 0);
    check("t3_data_stall", stall_bad, 0);
    check("t3_data_rdata", data_rdata, 32'h11112222);

    // Data read, arready stalled 5 cycles, SLVERR, extra non-last beat
    @(negedge clk); auto_en = 0; clear_slave();
    data_addr = 32'h90000040; data_we = '0; data_req = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_arvalid_stall", arvalid, 1);
      check("t4_araddr_stall", araddr, 32'h90000040);
    end
    arready = 1;
    @(negedge clk); arready = 0;
    check("t4_arvalid_drop", arvalid, 0);
    check("t4_rready", rready, 1);
    rvalid = 1; rlast = 0; rdata = 32'hAAAAAAAA; rresp = 2'b10;
    @(negedge clk);
    check("t4_nonlast_no_done", data_done, 0);
    check("t4_nonlast_discard", data_rdata, 32'h11112222);
    rlast = 1; rdata = 32'h5555AAAA;
    @(negedge clk); rvalid = 0; rlast = 0;
    check("t4_done_err", data_done, 1);
    check("t4_rdata", data_rdata, 32'h5555AAAA);
    data_req = 0;
    @(negedge clk);
    check("t4_done_pulse", data_done, 0);

    // Reset while RDATA has rvalid pending
    inst_addr = 32'hBFC00100; inst_req = 1;
    @(negedge clk);
    check("t5_arvalid", arvalid, 1);
    arready = 1;
    @(negedge clk); arready = 0;
    check("t5_rready", rready, 1);
    rvalid = 1; rlast = 1; rdata = 32'hFFFF0000;
    #2 rst = 0;
    #1;
    check("t5_rst_rready", rready, 0);
    check("t5_rst_arvalid", arvalid, 0);
    check("t5_rst_rdata", inst_rdata, 0);
    @(negedge clk);
    check("t5_rst_no_done", inst_done, 0);
    check("t5_rst_rready2", rready, 0);
    rvalid = 0; rlast = 0;
    auto_rdata = 32'h0BADF00D; auto_en = 1;
    rst = 1;
    found = 0;
    for (int cyc = 0; cyc < 10 && !found; cyc++) begin
      @(negedge clk);
      if (arvalid) check("t5_re_araddr", araddr, 32'hBFC00100);
      if (inst_done) found = 1;
    end
    check("t5_re_done", found, 1);
    check("t5_re_rdata", inst_rdata, 32'h0BADF00D);
    inst_req = 0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
